// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for the five-stage OTTER pipeline.
// Tracks the destination registers of the instructions in EX and MEM, raises
// load-use stall / branch flush / EX bubble controls, registers the EX-stage
// operand-mux selects and keeps saturating stall and flush event counters.
module hazard_fwd_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush,
    output logic             bubble_ex,
    output logic [2:0]       fwd_a_sel,
    output logic [2:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] SEL_RF  = 3'd0;
    localparam logic [2:0] SEL_EXM = 3'd1;
    localparam logic [2:0] SEL_MWB = 3'd2;

    // In-flight producer slots; WB is not tracked (write-first register file).
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_we;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic load_use;

    // Youngest producer wins: EX slot beats MEM slot.
    function automatic logic [2:0] pick_sel(input logic ex_m, input logic mem_m);
        if (ex_m)
            return SEL_EXM;
        else if (mem_m)
            return SEL_MWB;
        else
            return SEL_RF;
    endfunction

    // Source-match detection and stall/flush/bubble generation, forced low in reset.
    always_comb begin
        ex_m1  = id_valid && id_rs1_used && (id_rs1 != 5'd0) && ex_we  && (ex_rd  == id_rs1);
        ex_m2  = id_valid && id_rs2_used && (id_rs2 != 5'd0) && ex_we  && (ex_rd  == id_rs2);
        mem_m1 = id_valid && id_rs1_used && (id_rs1 != 5'd0) && mem_we && (mem_rd == id_rs1);
        mem_m2 = id_valid && id_rs2_used && (id_rs2 != 5'd0) && mem_we && (mem_rd == id_rs2);

        load_use  = !RST && ex_ld && (ex_m1 || ex_m2);
        flush     = !RST && ex_branch_taken;
        stall     = load_use && !flush;
        bubble_ex = load_use || flush;
    end

    // Slot advance and registered operand selects for the instruction entering EX.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_rd     <= '0;
            ex_we     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_rd    <= '0;
            mem_we    <= 1'b0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            mem_rd <= ex_rd;
            mem_we <= ex_we;
            if (bubble_ex) begin
                ex_rd     <= '0;
                ex_we     <= 1'b0;
                ex_ld     <= 1'b0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end else begin
                ex_rd     <= id_rd;
                ex_we     <= id_rd_we && id_valid;
                ex_ld     <= id_is_load && id_valid;
                fwd_a_sel <= pick_sel(ex_m1, mem_m1);
                fwd_b_sel <= pick_sel(ex_m2, mem_m2);
            end
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
